// File: rtl/sky130_sram_1rw1r_param.sv
// sky130_sram_1rw1r_param
// Parameterised SRAM with one read/write port (port 0) and one read-only
// port (port 1), both on clk0. A zero-fill sequence (INIT) runs after reset
// when INIT_ON_RESET=1. Until it ends, ready is low and all accesses are ignored.
//
// Ports:
//   clk0      - rising-edge clock for both ports
//   rst0      - asynchronous active-high reset
//   csb0/web0 - port 0 chip select / write enable (both active low)
//   wmask0    - port 0 write lane mask, 1 = write that lane
//   addr0     - port 0 address
//   din0      - port 0 write data
//   dout0     - port 0 read data
//   csb1      - port 1 chip select (active low)
//   addr1     - port 1 address
//   dout1     - port 1 read data
//   ready     - high while accesses are accepted
//   collision - one-cycle pulse after a same-address port-0 write / port-1 read
//   addr_err  - one-cycle pulse after an accepted access at address >= RAM_DEPTH
module sky130_sram_1rw1r_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 256,
    parameter int WMASK_GRAN    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 1,
    parameter int INIT_ON_RESET = 1,
    localparam int NUM_WMASKS   = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  ready,
    output logic                  collision,
    output logic                  addr_err
);

    // One extra bit so that RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   init_cnt_r;
    logic                    ready_r;
    logic                    collision_r;
    logic                    addr_err_r;
    logic [DATA_WIDTH-1:0]   dout0_r;
    logic [DATA_WIDTH-1:0]   dout1_r;
    logic                    p0_v_r;
    logic                    p1_v_r;
    logic [DATA_WIDTH-1:0]   p0_d_r;
    logic [DATA_WIDTH-1:0]   p1_d_r;
    logic [DATA_WIDTH-1:0]   mem_r [RAM_DEPTH];

    logic                    wr0_s;
    logic                    rd0_s;
    logic                    rd1_s;
    logic                    ok0_s;
    logic                    ok1_s;
    logic                    collide_s;
    logic [DATA_WIDTH-1:0]   word0_s;
    logic [DATA_WIDTH-1:0]   word1_s;
    logic [DATA_WIDTH-1:0]   rd1_data_s;

    // Replace the lanes selected by mask in old_w with the lanes of new_w.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*WMASK_GRAN +: WMASK_GRAN] = new_w[i*WMASK_GRAN +: WMASK_GRAN];
            end else begin
                res[i*WMASK_GRAN +: WMASK_GRAN] = old_w[i*WMASK_GRAN +: WMASK_GRAN];
            end
        end
        return res;
    endfunction

    // Access qualification, out-of-range detection and read-data selection.
    always_comb begin
        wr0_s = ready_r & ~csb0 & ~web0;
        rd0_s = ready_r & ~csb0 & web0;
        rd1_s = ready_r & ~csb1;
        ok0_s = ({1'b0, addr0} < DEPTH_W);
        ok1_s = ({1'b0, addr1} < DEPTH_W);
        collide_s = wr0_s & rd1_s & ok0_s & (addr0 == addr1);
        if (ok0_s) begin
            word0_s = mem_r[addr0];
        end else begin
            word0_s = '0;
        end
        if (ok1_s) begin
            word1_s = mem_r[addr1];
        end else begin
            word1_s = '0;
        end
        // Write-through forwarding: the read sees the lanes being written now.
        if (collide_s && (RDW_MODE == 1)) begin
            rd1_data_s = merge_lanes(word1_s, din0, wmask0);
        end else begin
            rd1_data_s = word1_s;
        end
    end

    // Control FSM, status pulses and read pipeline / output registers.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_r     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt_r  <= '0;
            ready_r     <= 1'b0;
            collision_r <= 1'b0;
            addr_err_r  <= 1'b0;
            p0_v_r      <= 1'b0;
            p1_v_r      <= 1'b0;
            p0_d_r      <= '0;
            p1_d_r      <= '0;
            dout0_r     <= '0;
            dout1_r     <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        init_cnt_r <= init_cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= '0;
                    ready_r    <= 1'b0;
                end
            endcase
            collision_r <= collide_s;
            addr_err_r  <= ((wr0_s | rd0_s) & ~ok0_s) | (rd1_s & ~ok1_s);
            if (READ_LATENCY == 2) begin
                p0_v_r <= rd0_s;
                p1_v_r <= rd1_s;
                p0_d_r <= word0_s;
                p1_d_r <= rd1_data_s;
                if (p0_v_r) begin
                    dout0_r <= p0_d_r;
                end
                if (p1_v_r) begin
                    dout1_r <= p1_d_r;
                end
            end else begin
                if (rd0_s) begin
                    dout0_r <= word0_s;
                end
                if (rd1_s) begin
                    dout1_r <= rd1_data_s;
                end
            end
        end
    end

    // Storage array: zero-fill during INIT, masked writes during RUN.
    // No reset here so contents survive a reset when no fill is requested.
    always_ff @(posedge clk0) begin
        if (!rst0 && (state_r == ST_INIT)) begin
            mem_r[init_cnt_r] <= '0;
        end else if (wr0_s && ok0_s) begin
            mem_r[addr0] <= merge_lanes(mem_r[addr0], din0, wmask0);
        end
    end

    assign dout0     = dout0_r;
    assign dout1     = dout1_r;
    assign ready     = ready_r;
    assign collision = collision_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Testbench for sky130_sram_1rw1r_param. Two instances share the stimulus:
//   dut_a: defaults (256 words, latency 1, new-data read-during-write)
//   dut_b: 200 words, latency 2, old-data read-during-write
// A word-level reference model predicts every output of both instances.
module tb_sky130_sram_1rw1r_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
    logic [3:0]  wmask0 = 4'h0;
    logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
    logic [31:0] din0 = 32'h0;

    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_ready, a_col, a_err, b_ready, b_col, b_err;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;

    // Reference model state
    logic [31:0] m_a [256];
    logic [31:0] m_b [200];
    logic [31:0] e_a0, e_a1, e_b0, e_b1, pd0, pd1;
    logic        pv0, pv1, e_col_a, e_col_b, e_err_b;

    sky130_sram_1rw1r_param dut_a (
        .clk0(clk), .rst0(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(a_dout0), .csb1(csb1), .addr1(addr1),
        .dout1(a_dout1), .ready(a_ready), .collision(a_col), .addr_err(a_err)
    );

    sky130_sram_1rw1r_param #(
        .RAM_DEPTH(200), .READ_LATENCY(2), .RDW_MODE(0)
    ) dut_b (
        .clk0(clk), .rst0(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(b_dout0), .csb1(csb1), .addr1(addr1),
        .dout1(b_dout1), .ready(b_ready), .collision(b_col), .addr_err(b_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane_mix(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] m);
        logic [31:0] keep;
        keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (n & keep) | (o & ~keep);
    endfunction

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    // Predict this edge's effects on both instances, then clock it.
    task automatic step();
        bit ra, wa, ra0, ra1, rb, wb, rb0, rb1, okb0, okb1;
        ra  = (edges >= 256);
        rb  = (edges >= 200);
        wa  = ra && !csb0 && !web0;
        ra0 = ra && !csb0 && web0;
        ra1 = ra && !csb1;
        e_col_a = wa && ra1 && (addr0 == addr1);
        if (ra0) e_a0 = m_a[addr0];
        if (ra1) e_a1 = e_col_a ? lane_mix(m_a[addr1], din0, wmask0) : m_a[addr1];
        if (wa) m_a[addr0] = lane_mix(m_a[addr0], din0, wmask0);
        wb   = rb && !csb0 && !web0;
        rb0  = rb && !csb0 && web0;
        rb1  = rb && !csb1;
        okb0 = (addr0 < 8'd200);
        okb1 = (addr1 < 8'd200);
        e_col_b = wb && rb1 && okb0 && (addr0 == addr1);
        e_err_b = ((wb || rb0) && !okb0) || (rb1 && !okb1);
        if (pv0) e_b0 = pd0;
        if (pv1) e_b1 = pd1;
        pv0 = rb0;
        pv1 = rb1;
        pd0 = okb0 ? m_b[addr0] : 32'h0;
        pd1 = okb1 ? m_b[addr1] : 32'h0;
        if (wb && okb0) m_b[addr0] = lane_mix(m_b[addr0], din0, wmask0);
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic assert_rst();
        idle();
        rst = 1'b1;
        e_a0 = 32'h0; e_a1 = 32'h0; e_b0 = 32'h0; e_b1 = 32'h0;
        pv0 = 1'b0; pv1 = 1'b0; pd0 = 32'h0; pd1 = 32'h0;
        e_col_a = 1'b0; e_col_b = 1'b0; e_err_b = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        edges = 0;
        for (int i = 0; i < 256; i++) m_a[i] = 32'h0;
        for (int i = 0; i < 200; i++) m_b[i] = 32'h0;
    endtask

    task automatic test_reset();
        #2;
        assert_rst();
        n_cmp++; if (a_dout0 !== 32'h0) begin n_err++; $display("FAIL reset_a_dout0: got %h want 0", a_dout0); end
        n_cmp++; if (a_dout1 !== 32'h0) begin n_err++; $display("FAIL reset_a_dout1: got %h want 0", a_dout1); end
        n_cmp++; if ({a_ready, a_col, a_err} !== 3'b000) begin n_err++; $display("FAIL reset_a_flags: got %b want 000", {a_ready, a_col, a_err}); end
        n_cmp++; if (b_dout0 !== 32'h0 || b_dout1 !== 32'h0) begin n_err++; $display("FAIL reset_b_dout: got %h %h want 0 0", b_dout0, b_dout1); end
        n_cmp++; if ({b_ready, b_col, b_err} !== 3'b000) begin n_err++; $display("FAIL reset_b_flags: got %b want 000", {b_ready, b_col, b_err}); end
        release_rst();
    endtask

    // Writes attempted during INIT must be ignored; ready timing checked every clock.
    task automatic test_init();
        for (int i = 0; i < 260; i++) begin
            if (edges < 250) begin
                set_wr(8'($urandom_range(0, 255)), $urandom, 4'hF);
                csb1 = 1'b0; addr1 = 8'($urandom_range(0, 255));
            end else begin
                idle();
            end
            step();
            n_cmp++; if (a_ready !== (edges >= 256)) begin n_err++; $display("FAIL init_a_ready edge %0d: got %b want %b", edges, a_ready, edges >= 256); end
            n_cmp++; if (b_ready !== (edges >= 200)) begin n_err++; $display("FAIL init_b_ready edge %0d: got %b want %b", edges, b_ready, edges >= 200); end
            n_cmp++; if (b_err !== e_err_b) begin n_err++; $display("FAIL init_b_err edge %0d: got %b want %b", edges, b_err, e_err_b); end
        end
        idle();
    endtask

    task automatic test_zero_fill();
        for (int i = 0; i < 256; i++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = 8'(255 - i);
            csb1 = 1'b0; addr1 = 8'(i);
            step();
            n_cmp++; if (a_dout0 !== 32'h0 || a_dout1 !== 32'h0) begin n_err++; $display("FAIL zero_fill_a addr %0d: got %h %h want 0 0", i, a_dout0, a_dout1); end
            n_cmp++; if (b_dout0 !== e_b0 || b_dout1 !== e_b1) begin n_err++; $display("FAIL zero_fill_b addr %0d: got %h %h want %h %h", i, b_dout0, b_dout1, e_b0, e_b1); end
        end
        idle();
    endtask

    task automatic test_masked_write();
        set_wr(8'h10, 32'hDEADBEEF, 4'b1111); step();
        set_wr(8'h10, 32'h11223344, 4'b0101); step();
        idle(); csb1 = 1'b0; addr1 = 8'h10; step();
        idle();
        n_cmp++; if (a_dout1 !== 32'hDE22BE44) begin n_err++; $display("FAIL masked_a_dout1: got %h want de22be44", a_dout1); end
        step();
        n_cmp++; if (b_dout1 !== 32'hDE22BE44) begin n_err++; $display("FAIL masked_b_dout1: got %h want de22be44", b_dout1); end
    endtask

    task automatic test_rdw();
        set_wr(8'd5, 32'h12345678, 4'hF); step();
        set_wr(8'd5, 32'hAAAAAAAA, 4'b0011); csb1 = 1'b0; addr1 = 8'd5; step();
        idle();
        n_cmp++; if (a_dout1 !== 32'h1234AAAA) begin n_err++; $display("FAIL rdw_a_dout1: got %h want 1234aaaa", a_dout1); end
        n_cmp++; if (a_col !== 1'b1 || b_col !== 1'b1) begin n_err++; $display("FAIL rdw_col_pulse: got %b %b want 1 1", a_col, b_col); end
        step();
        n_cmp++; if (b_dout1 !== 32'h12345678) begin n_err++; $display("FAIL rdw_b_dout1: got %h want 12345678", b_dout1); end
        n_cmp++; if (a_col !== 1'b0 || b_col !== 1'b0) begin n_err++; $display("FAIL rdw_col_end: got %b %b want 0 0", a_col, b_col); end
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd5; step(); idle(); step();
        n_cmp++; if (a_dout0 !== 32'h1234AAAA || b_dout0 !== 32'h1234AAAA) begin n_err++; $display("FAIL rdw_readback: got %h %h want 1234aaaa", a_dout0, b_dout0); end
    endtask

    task automatic test_addr_err();
        set_wr(8'd20, 32'h5A5A5A5A, 4'hF); step();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd20; step();
        set_wr(8'd220, 32'hFFFFFFFF, 4'hF); step();
        n_cmp++; if (b_dout0 !== 32'h5A5A5A5A) begin n_err++; $display("FAIL err_b_pre: got %h want 5a5a5a5a", b_dout0); end
        n_cmp++; if (b_err !== 1'b1 || a_err !== 1'b0) begin n_err++; $display("FAIL err_wr_pulse: got b=%b a=%b want 1 0", b_err, a_err); end
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd220; csb1 = 1'b0; addr1 = 8'd230; step();
        n_cmp++; if (b_err !== 1'b1) begin n_err++; $display("FAIL err_rd_pulse: got %b want 1", b_err); end
        idle(); step();
        n_cmp++; if (b_dout0 !== 32'h0 || b_dout1 !== 32'h0) begin n_err++; $display("FAIL err_rd_data: got %h %h want 0 0", b_dout0, b_dout1); end
        n_cmp++; if (b_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_end: got %b want 0", b_err); end
        csb1 = 1'b0; addr1 = 8'd20; step(); idle(); step();
        n_cmp++; if (b_dout1 !== 32'h5A5A5A5A) begin n_err++; $display("FAIL err_alias: got %h want 5a5a5a5a", b_dout1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [5];
        set_wr(8'd1, 32'hA, 4'hF); step();
        set_wr(8'd2, 32'hB, 4'hF); step();
        set_wr(8'd3, 32'hC, 4'hF); step();
        want[0] = b_dout0; want[1] = 32'hA; want[2] = 32'hB; want[3] = 32'hC; want[4] = 32'hC;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                csb0 = 1'b0; web0 = 1'b1; addr0 = 8'(i + 1);
            end else begin
                idle();
            end
            step();
            n_cmp++; if (b_dout0 !== want[i]) begin n_err++; $display("FAIL b2b_lat2 slot %0d: got %h want %h", i, b_dout0, want[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = $urandom_range(0, 1);
            wmask0 = 4'($urandom);
            din0   = $urandom;
            addr0  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(190, 255));
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = ($urandom_range(0, 2) == 0) ? addr0 : 8'($urandom_range(0, 255));
            step();
            n_cmp++; if (a_dout0 !== e_a0) begin n_err++; $display("FAIL rand_a_dout0 %0d: got %h want %h", i, a_dout0, e_a0); end
            n_cmp++; if (a_dout1 !== e_a1) begin n_err++; $display("FAIL rand_a_dout1 %0d: got %h want %h", i, a_dout1, e_a1); end
            n_cmp++; if ({a_ready, a_col, a_err} !== {1'b1, e_col_a, 1'b0}) begin n_err++; $display("FAIL rand_a_flags %0d: got %b want %b", i, {a_ready, a_col, a_err}, {1'b1, e_col_a, 1'b0}); end
            n_cmp++; if (b_dout0 !== e_b0) begin n_err++; $display("FAIL rand_b_dout0 %0d: got %h want %h", i, b_dout0, e_b0); end
            n_cmp++; if (b_dout1 !== e_b1) begin n_err++; $display("FAIL rand_b_dout1 %0d: got %h want %h", i, b_dout1, e_b1); end
            n_cmp++; if ({b_ready, b_col, b_err} !== {1'b1, e_col_b, e_err_b}) begin n_err++; $display("FAIL rand_b_flags %0d: got %b want %b", i, {b_ready, b_col, b_err}, {1'b1, e_col_b, e_err_b}); end
        end
        idle();
    endtask

    // Reset in RUN clears outputs at once; reset mid-INIT restarts the fill.
    task automatic test_reset_reinit();
        int na, nb;
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'd5; step();
        assert_rst();
        n_cmp++; if (a_dout0 !== 32'h0 || a_dout1 !== 32'h0 || b_dout0 !== 32'h0 || b_dout1 !== 32'h0) begin n_err++; $display("FAIL rerst_dout: got %h %h %h %h want 0", a_dout0, a_dout1, b_dout0, b_dout1); end
        n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_err++; $display("FAIL rerst_ready: got %b want 00", {a_ready, b_ready}); end
        release_rst();
        for (int i = 0; i < 100; i++) step();
        assert_rst();
        n_cmp++; if ({a_ready, a_col, a_err, b_ready} !== 4'b0000) begin n_err++; $display("FAIL init_rst_flags: got %b want 0000", {a_ready, a_col, a_err, b_ready}); end
        release_rst();
        na = 0; nb = 0;
        while (!a_ready && na < 300) begin
            step();
            na++;
            if (b_ready && nb == 0) nb = na;
        end
        n_cmp++; if (na != 256) begin n_err++; $display("FAIL reinit_a_len: got %0d clocks want 256", na); end
        n_cmp++; if (nb != 200) begin n_err++; $display("FAIL reinit_b_len: got %0d clocks want 200", nb); end
        csb1 = 1'b0; addr1 = 8'h10; step(); idle(); step();
        n_cmp++; if (a_dout1 !== 32'h0 || b_dout1 !== 32'h0) begin n_err++; $display("FAIL reinit_zero: got %h %h want 0 0", a_dout1, b_dout1); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_zero_fill();
        test_masked_write();
        test_rdw();
        test_addr_err();
        test_back_to_back();
        test_random();
        test_reset_reinit();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
